lif_config_sequencer: RTL
=========================

# lif_config_sequencer

Sequencer that programs the LIF neuron system's serial parameter loader and gates the neuron's run enable. On a start request it latches a parallel parameter set and shifts it out as a fixed 24-bit serial frame on `load_mode`/`serial_data`. It then waits for the loader's `params_ready` acknowledge and enables the neuron only after that acknowledge. It sits between host/test logic and the `enable`, `load_mode` and `serial_data` inputs of the neuron system.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles to wait for `params_ready` after the frame ends (range 1..255).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to (re)program; sampled each cycle.
- `abort`  in  1  force return to IDLE; has priority over `start`.
- `cfg_weight_a`  in  3  channel A weight.
- `cfg_weight_b`  in  3  channel B weight.
- `cfg_leak`  in  2  leak configuration.
- `cfg_thr_min`  in  8  minimum threshold.
- `cfg_thr_max`  in  8  maximum threshold.
- `params_ready`  in  1  loader acknowledge, level.
- `load_mode`  out  1  loader shift enable.
- `serial_data`  out  1  loader serial bit.
- `neuron_en`  out  1  neuron/system run enable.
- `busy`  out  1  high in SHIFT and WAIT_READY.
- `done`  out  1  one-cycle pulse on entry to RUN.
- `cfg_err`  out  1  sticky timeout flag.

## Operation
- Frame: 24 bits, MSB first, in the order `cfg_weight_a`, `cfg_weight_b`, `cfg_leak`, `cfg_thr_min`, `cfg_thr_max`. Frame bit 23 = `cfg_weight_a[2]`; frame bit 0 = `cfg_thr_max[0]`.
- States: IDLE, SHIFT, WAIT_READY, RUN, ERROR.
- IDLE: all outputs 0. On `start` = 1, latch the cfg inputs into a 24-bit shift register, clear the 5-bit bit counter, clear `cfg_err`, and go to SHIFT.
- SHIFT: `load_mode` = 1 and `serial_data` = shift register MSB. Shift left each cycle and increment the bit counter. After the 24th bit, go to WAIT_READY. `start` is ignored in SHIFT.
- WAIT_READY: `load_mode` = 0 and `serial_data` = 0. A wait counter increments each cycle.
  - On `params_ready` = 1, go to RUN.
  - If the counter reaches `TIMEOUT_CYCLES` with `params_ready` still 0, go to ERROR. If both events occur in the same cycle, `params_ready` wins.
  - `start` is ignored in WAIT_READY.
- RUN: `neuron_en` = 1. On `start` = 1, latch new cfg values, drop `neuron_en`, and go to SHIFT.
- ERROR: `cfg_err` = 1 and `neuron_en` = 0. On `start` = 1, clear `cfg_err` and behave as the IDLE start.
- `abort` = 1 in any state: next state is IDLE and the shift state is cleared. `cfg_err` keeps its value.
- All outputs are registered.

## Timing
- Reset values: state IDLE; `load_mode`, `serial_data`, `neuron_en`, `busy`, `done` and `cfg_err` all 0.
- Start accepted at edge N: `load_mode` is high from N+1 through N+24 inclusive, with frame bit 23−k driven during cycle N+1+k.
- `params_ready` first seen high at edge M: `neuron_en` = 1 and `done` = 1 from M+1. `done` falls at M+2.
- Timeout: a `params_ready` that stays low gives `cfg_err` = 1 exactly `TIMEOUT_CYCLES` cycles after the last frame bit.
- Reconfigure from RUN with `start` at edge R: `neuron_en` = 0 from R+1, and the next frame starts at R+1.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). After reset release, no frame resumes.

## Configuration
- `LIF_CFG_TIMEOUT_EN` defined: the WAIT_READY watchdog, ERROR state and `cfg_err` behave as described above.
- `LIF_CFG_TIMEOUT_EN` undefined: no wait counter and no ERROR state. WAIT_READY waits indefinitely for `params_ready`. `cfg_err` is tied to 0. `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset, then `start` with wa=5, wb=3, leak=2, thr_min=0x20, thr_max=0x60 -> `load_mode` high for 24 cycles; serial stream 101_011_10_00100000_01100000.
- Same start, `params_ready` raised 3 cycles after the frame -> `neuron_en` = 1 and a single-cycle `done` on the next edge; `busy` = 0 thereafter.
- `params_ready` held low, `TIMEOUT_CYCLES` = 8 with macro defined -> `cfg_err` = 1 eight cycles after the frame; `neuron_en` stays 0. A new `start` clears `cfg_err`.
- In RUN, `start` with new cfg wa=1 -> `neuron_en` drops next cycle; new frame begins with bits 001.
- `abort` at the 10th frame bit -> `load_mode` = 0 and state IDLE on the next edge. Repeat with async `reset` mid-frame -> all outputs 0 without waiting for a clock.
- `start` held high through SHIFT and WAIT_READY -> exactly one frame is sent; with `start` still high in RUN, a second frame begins.

Source files
------------

// File: rtl/lif_config_sequencer.sv
// rtl/lif_config_sequencer.sv - serial parameter frame loader and neuron run-enable sequencer
// Optional watchdog: define LIF_CFG_TIMEOUT_EN to enable the params_ready timeout,
// the ERROR state and the sticky cfg_err flag. Without it, WAIT_READY waits forever
// and cfg_err_o is tied low.
module lif_config_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [2:0] cfg_weight_a_i,
    input  logic [2:0] cfg_weight_b_i,
    input  logic [1:0] cfg_leak_i,
    input  logic [7:0] cfg_thr_min_i,
    input  logic [7:0] cfg_thr_max_i,
    input  logic       params_ready_i,
    output logic       load_mode_o,
    output logic       serial_data_o,
    output logic       neuron_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       cfg_err_o
);

    // The watchdog counter is 8 bits wide, so the timeout must fit in 1..255.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("lif_config_sequencer: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      state_q;
    logic [23:0] shreg_q;
    logic [4:0]  bitcnt_q;
    logic        load_mode_q;
    logic        serial_q;
    logic        neuron_en_q;
    logic        busy_q;
    logic        done_q;
`ifdef LIF_CFG_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  wcnt_q;
    logic        cfg_err_q;
`endif

    // Frame image, MSB first: weight_a, weight_b, leak, thr_min, thr_max.
    logic [23:0] frame_d;
    assign frame_d = {cfg_weight_a_i, cfg_weight_b_i, cfg_leak_i, cfg_thr_min_i, cfg_thr_max_i};

    // A start is only honoured from the states that are not mid-transfer.
    logic load_req;
    assign load_req = start_i && (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERROR);

    // Sequencer FSM; every output is registered from the state being entered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            load_mode_q <= 1'b0;
            serial_q    <= 1'b0;
            neuron_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LIF_CFG_TIMEOUT_EN
            wcnt_q      <= '0;
            cfg_err_q   <= 1'b0;
`endif
        end else if (abort_i) begin
            // cfg_err deliberately survives an abort so the host can still read it.
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            load_mode_q <= 1'b0;
            serial_q    <= 1'b0;
            neuron_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LIF_CFG_TIMEOUT_EN
            wcnt_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (load_req) begin
                state_q     <= S_SHIFT;
                shreg_q     <= frame_d;
                bitcnt_q    <= '0;
                load_mode_q <= 1'b1;
                serial_q    <= frame_d[23];
                neuron_en_q <= 1'b0;
                busy_q      <= 1'b1;
`ifdef LIF_CFG_TIMEOUT_EN
                wcnt_q      <= '0;
                cfg_err_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_SHIFT: begin
                        if (bitcnt_q == 5'd23) begin
                            state_q     <= S_WAIT;
                            load_mode_q <= 1'b0;
                            serial_q    <= 1'b0;
                        end else begin
                            shreg_q  <= {shreg_q[22:0], 1'b0};
                            serial_q <= shreg_q[22];
                            bitcnt_q <= bitcnt_q + 5'd1;
                        end
                    end
                    S_WAIT: begin
                        // An acknowledge in the timeout cycle still wins.
                        if (params_ready_i) begin
                            state_q     <= S_RUN;
                            neuron_en_q <= 1'b1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                        end
`ifdef LIF_CFG_TIMEOUT_EN
                        else if (wcnt_q == TO_LAST) begin
                            state_q   <= S_ERROR;
                            cfg_err_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            wcnt_q <= wcnt_q + 8'd1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load_mode_o   = load_mode_q;
    assign serial_data_o = serial_q;
    assign neuron_en_o   = neuron_en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
`ifdef LIF_CFG_TIMEOUT_EN
    assign cfg_err_o     = cfg_err_q;
`else
    assign cfg_err_o     = 1'b0;
`endif

endmodule
